// File: rtl/tlul_host_adapter.sv
// tlul_host_adapter: single-beat host request port bridged onto TL-UL A/D channels,
// with an in-order tracker that checks each D response against the request it answers.
module tlul_host_adapter #(
   parameter int MAX_REQS = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  be_i,
   output logic        valid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        a_valid_o,
   output logic [2:0]  a_opcode_o,
   output logic [1:0]  a_size_o,
   output logic [7:0]  a_source_o,
   output logic [31:0] a_address_o,
   output logic [3:0]  a_mask_o,
   output logic [31:0] a_data_o,
   input  logic        a_ready_i,
   input  logic        d_valid_i,
   input  logic [2:0]  d_opcode_i,
   input  logic [7:0]  d_source_i,
   input  logic [31:0] d_data_i,
   input  logic        d_error_i,
   output logic        d_ready_o
);
   localparam logic [2:0] MAXC = 3'(MAX_REQS);
   localparam logic [1:0] LAST = 2'(MAX_REQS - 1);
   logic [2:0] cnt;
   logic [1:0] src, wr, rd;
   logic       fifo_we  [4];
   logic [1:0] fifo_src [4];
   logic       a_hs, d_hs, empty, head_we, d_err;

   function automatic logic [1:0] inc(input logic [1:0] p);
      return (p == LAST) ? 2'd0 : p + 2'd1;
   endfunction

   assign d_ready_o = rst_ni;
   assign a_hs      = a_valid_o & a_ready_i;
   assign d_hs      = d_valid_i & d_ready_o;
   assign empty     = cnt == 3'd0;
   assign head_we   = fifo_we[rd];
   // the held A beat counts against the limit: it is already committed to become outstanding
   assign gnt_o     = rst_ni & req_i & (~a_valid_o | a_ready_i) & ((cnt + {2'b0, a_valid_o}) < MAXC);
   assign d_err     = empty | d_error_i | (d_opcode_i != (head_we ? 3'h0 : 3'h1))
                    | (d_source_i != {6'b0, fifo_src[rd]});

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_valid_o   <= 1'b0;
         a_opcode_o  <= 3'h0;
         a_size_o    <= 2'h0;
         a_source_o  <= 8'h0;
         a_address_o <= 32'h0;
         a_mask_o    <= 4'h0;
         a_data_o    <= 32'h0;
         src         <= 2'd0;
         wr          <= 2'd0;
         rd          <= 2'd0;
         cnt         <= 3'd0;
         valid_o     <= 1'b0;
         err_o       <= 1'b0;
         rdata_o     <= 32'h0;
      end else begin
         if (gnt_o) begin
            a_valid_o   <= 1'b1;
            a_opcode_o  <= we_i ? ((be_i == 4'hF) ? 3'h0 : 3'h1) : 3'h4;
            a_size_o    <= 2'd2;
            a_source_o  <= {6'b0, src};
            a_address_o <= {addr_i[31:2], 2'b00};
            a_mask_o    <= we_i ? be_i : 4'hF;
            a_data_o    <= we_i ? wdata_i : 32'h0;
            src         <= inc(src);
         end else if (a_hs) begin
            a_valid_o <= 1'b0;
         end
         if (a_hs) wr <= inc(wr);
         if (d_hs & ~empty) rd <= inc(rd);
         cnt     <= cnt + {2'b0, a_hs} - {2'b0, d_hs & ~empty};
         valid_o <= d_hs;
         err_o   <= d_hs & d_err;
         if (d_hs) rdata_o <= (d_err | head_we) ? 32'h0 : d_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (a_hs) begin
         fifo_we[wr]  <= a_opcode_o != 3'h4;
         fifo_src[wr] <= a_source_o[1:0];
      end
   end
endmodule

// File: tb/tb_tlul_host_adapter.sv
// tb_tlul_host_adapter: directed and random traffic checked against a queue-based
// transaction model of the adapter.
module tb_tlul_host_adapter;
   localparam int MAX = 2;
   logic clk_i = 0, rst_ni = 1, req_i = 0, we_i = 0, a_ready_i = 0;
   logic d_valid_i = 0, d_error_i = 0;
   logic [31:0] addr_i = 0, wdata_i = 0, d_data_i = 0;
   logic [3:0] be_i = 0;
   logic [2:0] d_opcode_i = 0;
   logic [7:0] d_source_i = 0;
   logic gnt_o, valid_o, err_o, a_valid_o, d_ready_o;
   logic [31:0] rdata_o, a_address_o, a_data_o;
   logic [2:0] a_opcode_o;
   logic [1:0] a_size_o;
   logic [7:0] a_source_o;
   logic [3:0] a_mask_o;

   tlul_host_adapter #(.MAX_REQS(MAX)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
      .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i), .valid_o(valid_o), .rdata_o(rdata_o),
      .err_o(err_o), .a_valid_o(a_valid_o), .a_opcode_o(a_opcode_o), .a_size_o(a_size_o),
      .a_source_o(a_source_o), .a_address_o(a_address_o), .a_mask_o(a_mask_o),
      .a_data_o(a_data_o), .a_ready_i(a_ready_i), .d_valid_i(d_valid_i),
      .d_opcode_i(d_opcode_i), .d_source_i(d_source_i), .d_data_i(d_data_i),
      .d_error_i(d_error_i), .d_ready_o(d_ready_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {logic we; logic [7:0] src;} txn_t;
   txn_t q[$];
   int errors = 0, checks = 0, nsrc = 0;
   logic h_v = 0, h_we = 0;
   logic [2:0] h_op = 0;
   logic [31:0] h_addr = 0, h_data = 0;
   logic [3:0] h_mask = 0;
   logic [7:0] h_src = 0;
   logic e_v = 0, e_err = 0;
   logic [31:0] e_rdata = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_gnt"}, gnt_o, 0);
      chk({tag, "_avalid"}, a_valid_o, 0);
      chk({tag, "_dready"}, d_ready_o, 0);
      chk({tag, "_valid"}, valid_o, 0);
      chk({tag, "_err"}, err_o, 0);
      chk({tag, "_rdata"}, rdata_o, 0);
      chk({tag, "_afields"}, {a_opcode_o, a_size_o, a_source_o, a_mask_o}, 0);
      chk({tag, "_aaddr"}, a_address_o, 0);
      chk({tag, "_adata"}, a_data_o, 0);
   endtask

   // entered at posedge+1; leaves at the next posedge+1
   task automatic do_reset();
      rst_ni = 0;
      req_i = 1;
      #1 chk_zero("rst_async");
      @(posedge clk_i); #1;
      chk_zero("rst_held");
      rst_ni = 1;
      q.delete();
      h_v = 0; nsrc = 0; e_v = 0; e_err = 0; e_rdata = 0;
   endtask

   task automatic step(input logic rq, input logic w, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [3:0] be, input logic ar, input logic dv, input logic [2:0] dop,
                       input logic [7:0] dsrc, input logic [31:0] dd, input logic de);
      logic eg;
      txn_t t;
      req_i = rq; we_i = w; addr_i = ad; wdata_i = wd; be_i = be; a_ready_i = ar;
      d_valid_i = dv; d_opcode_i = dop; d_source_i = dsrc; d_data_i = dd; d_error_i = de;
      @(negedge clk_i);
      eg = rq & (!h_v | ar) & ((q.size() + int'(h_v)) < MAX);
      chk("gnt", gnt_o, eg);
      chk("d_ready", d_ready_o, 1);
      chk("a_valid", a_valid_o, h_v);
      if (h_v) begin
         chk("a_opcode", a_opcode_o, h_op);
         chk("a_address", a_address_o, h_addr);
         chk("a_mask", a_mask_o, h_mask);
         chk("a_data", a_data_o, h_data);
         chk("a_source", a_source_o, h_src);
         chk("a_size", a_size_o, 2);
      end
      if (dv) begin
         e_v = 1;
         if (q.size() == 0) begin
            e_err = 1; e_rdata = 0;
         end else begin
            t = q.pop_front();
            e_err = de | (dop != (t.we ? 3'h0 : 3'h1)) | (dsrc != t.src);
            e_rdata = (e_err | t.we) ? 32'h0 : dd;
         end
      end else begin
         e_v = 0; e_err = 0;
      end
      if (h_v && ar) q.push_back('{h_we, h_src});
      if (eg) begin
         h_v = 1; h_we = w;
         h_op = w ? ((be == 4'hF) ? 3'h0 : 3'h1) : 3'h4;
         h_addr = {ad[31:2], 2'b00};
         h_mask = w ? be : 4'hF;
         h_data = w ? wd : 32'h0;
         h_src = 8'(nsrc);
         nsrc = (nsrc + 1) % MAX;
      end else if (h_v && ar) begin
         h_v = 0;
      end
      @(posedge clk_i); #1;
      chk("valid", valid_o, e_v);
      chk("err", err_o, e_err);
      chk("rdata", rdata_o, e_rdata);
   endtask

   task automatic rd_req(input logic [31:0] ad, input logic ar);
      step(1, 0, ad, 0, 0, ar, 0, 0, 0, 0, 0);
   endtask

   task automatic idle(input logic ar);
      step(0, 0, 0, 0, 0, ar, 0, 0, 0, 0, 0);
   endtask

   task automatic rsp(input logic rq, input logic [2:0] dop, input logic [7:0] s, input logic [31:0] dd, input logic de);
      step(rq, 0, 32'h2000_0000, 0, 0, 1, 1, dop, s, dd, de);
   endtask

   // a correctly formed reply to the oldest outstanding transaction
   task automatic rsp_ok(input logic rq, input logic [31:0] dd);
      if (q.size() == 0) rsp(rq, 3'h1, 0, dd, 0);
      else rsp(rq, q[0].we ? 3'h0 : 3'h1, q[0].src, dd, 0);
   endtask

   initial begin
      #1 do_reset();
      req_i = 0;
      rd_req(32'h1000_0007, 1);
      chk("r_opcode", a_opcode_o, 4);
      chk("r_addr", a_address_o, 32'h1000_0004);
      chk("r_mask", a_mask_o, 4'hF);
      chk("r_size", a_size_o, 2);
      chk("r_source", a_source_o, 0);
      idle(1);
      rsp(0, 3'h1, 0, 32'hDEAD_BEEF, 0);
      chk("r_valid", valid_o, 1);
      chk("r_rdata", rdata_o, 32'hDEAD_BEEF);
      chk("r_err", err_o, 0);
      idle(1);
      chk("r_hold", rdata_o, 32'hDEAD_BEEF);

      step(1, 1, 32'h3000_0002, 32'h1234_5678, 4'b0011, 1, 0, 0, 0, 0, 0);
      chk("pp_opcode", a_opcode_o, 1);
      chk("pp_mask", a_mask_o, 3);
      chk("pp_data", a_data_o, 32'h1234_5678);
      step(1, 1, 32'h3000_0010, 32'hCAFE_F00D, 4'hF, 1, 0, 0, 0, 0, 0);
      chk("pf_opcode", a_opcode_o, 0);
      chk("pf_source", a_source_o, 0);
      idle(1);
      rsp(0, 3'h0, 1, 32'hFFFF_FFFF, 0);
      chk("w_err", err_o, 0);
      chk("w_rdata", rdata_o, 0);
      rsp(0, 3'h0, 0, 32'h5555_5555, 0);
      chk("w2_valid", valid_o, 1);

      for (int i = 0; i < 4; i++) rd_req(32'h4000_0000 + 32'(i * 4), 1);
      chk("full_gnt", gnt_o, 0);
      rsp_ok(1, 32'h0000_00A1);
      rd_req(32'h4000_0100, 1);
      rd_req(32'h4000_0104, 1);
      rsp_ok(1, 32'h0000_00A2);
      rsp_ok(0, 32'h0000_00A3);
      rsp_ok(0, 32'h0000_00A4);
      rsp_ok(0, 32'h0000_00A5);

      rd_req(32'h5000_0008, 1);
      for (int i = 0; i < 5; i++) step(1, 1, 32'h6000_0000 + 32'(i), 32'(i), 4'h1, 0, 0, 0, 0, 0, 0);
      chk("stall_addr", a_address_o, 32'h5000_0008);
      step(1, 1, 32'h6000_0040, 32'h77, 4'h1, 1, 0, 0, 0, 0, 0);
      chk("nobubble_valid", a_valid_o, 1);
      chk("nobubble_addr", a_address_o, 32'h6000_0040);
      idle(1);
      rsp_ok(0, 32'h0000_00B1);
      rsp_ok(0, 32'h0000_00B2);

      rd_req(32'h7000_0000, 1); idle(1);
      rsp(0, 3'h1, q.size() ? q[0].src : 8'h0, 32'h1111_1111, 1);
      chk("e_derr", err_o, 1);
      rd_req(32'h7000_0004, 1); idle(1);
      rsp(0, 3'h0, q.size() ? q[0].src : 8'h0, 32'h2222_2222, 0);
      chk("e_opc", err_o, 1);
      rd_req(32'h7000_0008, 1); idle(1);
      rsp(0, 3'h1, q.size() ? q[0].src ^ 8'h1 : 8'h0, 32'h3333_3333, 0);
      chk("e_src", err_o, 1);
      chk("e_src_rdata", rdata_o, 0);
      rsp(0, 3'h1, 0, 32'h4444_4444, 0);
      chk("e_empty_valid", valid_o, 1);
      chk("e_empty_err", err_o, 1);
      chk("e_empty_rdata", rdata_o, 0);

      for (int i = 0; i < 300; i++) begin
         logic dv, de, w;
         logic [2:0] dop;
         logic [7:0] ds;
         int k;
         dv = $urandom_range(0, 2) == 0;
         de = 0; dop = 3'h1; ds = 0;
         if (q.size() != 0) begin
            dop = q[0].we ? 3'h0 : 3'h1;
            ds = q[0].src;
         end
         k = $urandom_range(0, 9);
         if (k == 0) de = 1;
         if (k == 1) dop = dop ^ 3'h1;
         if (k == 2) ds = ds ^ 8'h1;
         w = $urandom_range(0, 1) == 1;
         step($urandom_range(0, 2) != 0, w, $urandom, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3) != 0, dv, dop, ds, $urandom, de);
      end

      do_reset();
      req_i = 0;
      rd_req(32'h8000_0000, 1);
      idle(1);
      rd_req(32'h8000_0004, 0);
      chk("pre_rst_avalid", a_valid_o, 1);
      do_reset();
      req_i = 0;
      rd_req(32'h9000_0000, 1);
      chk("post_rst_source", a_source_o, 0);
      rsp(0, 3'h1, 0, 32'hABCD_0000, 0);
      chk("stale_err", err_o, 1);
      idle(1);
      rsp_ok(0, 32'h0BAD_F00D);
      chk("post_rst_rdata", rdata_o, 32'h0BAD_F00D);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
